// File: rtl/serial_word_assembler_pkg.sv
// Shared definitions for the serial word assembler.
// State names, bit-order constants and a clog2 helper.
package serial_word_assembler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_LAST    = 2'd2,
        ST_STALL   = 2'd3
    } swa_state_e;

    localparam logic BIT_ORDER_LSB = 1'b0;
    localparam logic BIT_ORDER_MSB = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_word_assembler_bit_order_mux.sv
// Passes a word straight through or bit-reversed.
// Used on the load path to honour the word's bit order.
module bit_order_mux #(
    parameter int width = 8
) (
    input  logic             sel,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout
);

    // sel = 1 mirrors the vector so bit 0 becomes the MSB
    always_comb begin
        dout = din;
        for (int i = 0; i < width; i++) begin
            dout[i] = sel ? din[width-1-i] : din[i];
        end
    end

endmodule

// File: rtl/serial_word_assembler.sv
// Serial-to-parallel deserializer, one bit per cycle in,
// one buffered word out, LSB- or MSB-first per word.
module serial_word_assembler
    import serial_word_assembler_pkg::*;
#(
    parameter  int width = 8,
    localparam int CW    = clog2(width)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             msb_first,
    input  logic             s_bit,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [width-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CW-1:0]    bit_count
);

    localparam logic [CW-1:0] LAST_CNT = CW'(width - 1);

    // Bit 0 of the word only exists once the word completes,
    // so the register keeps positions width-1 down to 1.
    logic [width-1:1] shift_q;
    logic [CW-1:0]    count;
    logic             order_q;

    logic [width-1:0] shift_next;
    logic [width-1:0] load_word;
    logic             accept;
    logic             load;
    swa_state_e       state;

    // Derive the input state from count and the output-full flag
    always_comb begin
        state = ST_COLLECT;
        unique case (1'b1)
            (count == '0):
                state = ST_IDLE;
            (count == LAST_CNT):
                state = (m_valid && !m_ready) ? ST_STALL : ST_LAST;
            default:
                state = ST_COLLECT;
        endcase
    end

    // Handshake and shift datapath; m_ready reaches s_ready on purpose
    always_comb begin
        s_ready    = !clear && (state != ST_STALL);
        accept     = s_valid && s_ready;
        load       = accept && (state == ST_LAST);
        shift_next = {s_bit, shift_q};
    end

    bit_order_mux #(
        .width (width)
    ) u_order_mux (
        .sel  (order_q),
        .din  (shift_next),
        .dout (load_word)
    );

    // Partial-word state: counter, shift register, latched bit order
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            shift_q <= '0;
            order_q <= BIT_ORDER_LSB;
        end else if (clear) begin
            count   <= '0;
            shift_q <= '0;
        end else if (load) begin
            count   <= '0;
            shift_q <= '0;
        end else if (accept) begin
            count   <= count + CW'(1);
            shift_q <= shift_next[width-1:1];
            if (state == ST_IDLE) begin
                order_q <= msb_first;
            end
        end
    end

    // One-entry output buffer; a load wins over a same-edge drain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data  <= '0;
            m_valid <= 1'b0;
        end else if (clear) begin
            m_valid <= 1'b0;
        end else if (load) begin
            m_data  <= load_word;
            m_valid <= 1'b1;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

    assign bit_count = count;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed bench for serial_word_assembler (width = 8).
// Inputs change 1 ns after the rising edge; checks follow.
module tb_serial_word_assembler;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic         clear;
    logic         msb_first;
    logic         s_bit;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic [2:0]   bit_count;

    int vectors;
    int miscompares;

    serial_word_assembler #(
        .width (W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .msb_first (msb_first),
        .s_bit     (s_bit),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .bit_count (bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic b, input logic mf);
        s_bit     = b;
        s_valid   = 1'b1;
        msb_first = mf;
    endtask

    task automatic send(input logic b, input logic mf);
        drive(b, mf);
        tick();
    endtask

    logic [7:0] w;
    logic       ready_ok;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        clear       = 1'b0;
        msb_first   = 1'b0;
        s_bit       = 1'b0;
        s_valid     = 1'b0;
        m_ready     = 1'b0;

        #12;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_bit_count", 32'(bit_count), 32'd0);
        reset_n = 1'b1;
        tick();

        // Test 1: LSB-first, stream 0,1,1,1,1,0,0,0 -> 0x1E
        m_ready = 1'b1;
        w = 8'h1E;
        for (int i = 0; i < 7; i++) send(w[i], 1'b0);
        chk("t1_count7", 32'(bit_count), 32'd7);
        chk("t1_not_yet", 32'(m_valid), 32'd0);
        send(w[7], 1'b0);
        s_valid = 1'b0;
        chk("t1_valid", 32'(m_valid), 32'd1);
        chk("t1_data", 32'(m_data), 32'h1E);
        chk("t1_count0", 32'(bit_count), 32'd0);
        tick();
        chk("t1_one_cycle", 32'(m_valid), 32'd0);

        // Test 2: MSB-first latched at bit 0, toggled at bit 4
        for (int i = 0; i < 8; i++) send(w[i], (i < 4) ? 1'b1 : 1'b0);
        s_valid = 1'b0;
        chk("t2_valid", 32'(m_valid), 32'd1);
        chk("t2_data", 32'(m_data), 32'h78);
        tick();

        // Test 3: back-pressure, 0x1E held, then 0xA5 on handshake
        m_ready = 1'b0;
        w = 8'h1E;
        for (int i = 0; i < 8; i++) send(w[i], 1'b0);
        w = 8'hA5;
        for (int i = 0; i < 7; i++) send(w[i], 1'b0);
        chk("t3_count7", 32'(bit_count), 32'd7);
        chk("t3_held_data", 32'(m_data), 32'h1E);
        drive(w[7], 1'b0);
        #1;
        chk("t3_stall", 32'(s_ready), 32'd0);
        @(posedge clk);
        #2;
        chk("t3_still_stall", 32'(s_ready), 32'd0);
        chk("t3_still_count", 32'(bit_count), 32'd7);
        chk("t3_still_valid", 32'(m_valid), 32'd1);
        chk("t3_still_data", 32'(m_data), 32'h1E);
        m_ready = 1'b1;
        #1;
        chk("t3_release", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        chk("t3_valid_kept", 32'(m_valid), 32'd1);
        chk("t3_data2", 32'(m_data), 32'hA5);
        chk("t3_count0", 32'(bit_count), 32'd0);
        tick();
        chk("t3_drained", 32'(m_valid), 32'd0);

        // Test 4: back-to-back 0xA5 then 0x3C, no bubble
        ready_ok = 1'b1;
        w = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            drive(w[i], 1'b0);
            #1;
            ready_ok = ready_ok & s_ready;
            tick();
        end
        chk("t4_valid1", 32'(m_valid), 32'd1);
        chk("t4_data1", 32'(m_data), 32'hA5);
        w = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            drive(w[i], 1'b0);
            #1;
            ready_ok = ready_ok & s_ready;
            tick();
            if (i == 0) chk("t4_gap", 32'(m_valid), 32'd0);
        end
        s_valid = 1'b0;
        chk("t4_valid2", 32'(m_valid), 32'd1);
        chk("t4_data2", 32'(m_data), 32'h3C);
        chk("t4_s_ready", 32'(ready_ok), 32'd1);
        tick();

        // Test 5: clear after 3 bits, then 0x5A with no residue
        w = 8'hFF;
        for (int i = 0; i < 3; i++) send(w[i], 1'b1);
        chk("t5_count3", 32'(bit_count), 32'd3);
        drive(1'b1, 1'b1);
        clear = 1'b1;
        #1;
        chk("t5_clr_ready", 32'(s_ready), 32'd0);
        tick();
        clear = 1'b0;
        chk("t5_clr_count", 32'(bit_count), 32'd0);
        chk("t5_clr_valid", 32'(m_valid), 32'd0);
        chk("t5_clr_data", 32'(m_data), 32'h3C);
        w = 8'h5A;
        for (int i = 0; i < 8; i++) send(w[i], 1'b0);
        s_valid = 1'b0;
        chk("t5_valid", 32'(m_valid), 32'd1);
        chk("t5_data", 32'(m_data), 32'h5A);
        tick();

        // Test 6: async reset with a full buffer and 5 bits pending
        m_ready = 1'b0;
        w = 8'hC3;
        for (int i = 0; i < 8; i++) send(w[i], 1'b0);
        for (int i = 0; i < 5; i++) send(w[i], 1'b0);
        s_valid = 1'b0;
        chk("t6_pre_valid", 32'(m_valid), 32'd1);
        chk("t6_pre_count", 32'(bit_count), 32'd5);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(m_valid), 32'd0);
        chk("t6_rst_data", 32'(m_data), 32'd0);
        chk("t6_rst_count", 32'(bit_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        m_ready = 1'b1;
        w = 8'h96;
        for (int i = 0; i < 8; i++) send(w[i], 1'b1);
        s_valid = 1'b0;
        chk("t6_valid", 32'(m_valid), 32'd1);
        chk("t6_data", 32'(m_data), 32'h69);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
